// File: rtl/axis_inject_arbiter.sv
// axis_inject_arbiter
// Packet-granular round-robin arbiter that shares one NoC router injection
// port between NUM_SRC AXI-Stream masters. A grant is taken in IDLE and held
// from the first beat until the TLAST handshake, so packets never interleave
// at the router. ENABLE gates only new grants; a packet-length watchdog
// raises a sticky LEN_ERR flag without truncating the packet.
module axis_inject_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int TDATAW    = 32,
  parameter int TDESTW    = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         ENABLE,
  input  logic [NUM_SRC-1:0]           S_TVALID,
  output logic [NUM_SRC-1:0]           S_TREADY,
  input  logic [NUM_SRC*TDATAW-1:0]    S_TDATA,
  input  logic [NUM_SRC-1:0]           S_TLAST,
  input  logic [NUM_SRC*TDESTW-1:0]    S_TDEST,
  output logic                         M_TVALID,
  input  logic                         M_TREADY,
  output logic [TDATAW-1:0]            M_TDATA,
  output logic                         M_TLAST,
  output logic [TDESTW-1:0]            M_TDEST,
  output logic                         BUSY,
  output logic [$clog2(NUM_SRC)-1:0]   GRANT_IDX,
  output logic                         LEN_ERR
);

  localparam int IDXW = $clog2(NUM_SRC);
  localparam int CNTW = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state;
  logic [IDXW-1:0]   rr_ptr;
  logic [IDXW-1:0]   grant_idx;
  logic [CNTW-1:0]   beat_cnt;
  logic              len_err;

  logic [IDXW-1:0]   pick_idx;
  logic              pick_vld;
  logic [IDXW:0]     cand;
  logic              beat;

  // Beat counter increment that sticks at MAX_BEATS so an over-long packet
  // cannot wrap the counter back into the legal range.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    if (v == CNTW'(MAX_BEATS)) return v;
    return v + CNTW'(1);
  endfunction

  // Modulo-NUM_SRC increment; NUM_SRC need not be a power of two.
  function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] v);
    if (v == IDXW'(NUM_SRC - 1)) return '0;
    return v + IDXW'(1);
  endfunction

  // Round-robin pick: scan from the farthest candidate down to rr_ptr so the
  // last write wins, which leaves the nearest requester at or after rr_ptr.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDXW + 1)'(k);
      if (cand >= (IDXW + 1)'(NUM_SRC)) cand = cand - (IDXW + 1)'(NUM_SRC);
      if (S_TVALID[cand[IDXW-1:0]]) begin
        pick_idx = cand[IDXW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  // Output mux: data/last/dest always follow the granted source (they are
  // only meaningful with M_TVALID), while valid and ready are forced low in
  // IDLE so nothing can transfer during the arbitration bubble.
  always_comb begin
    S_TREADY = '0;
    M_TVALID = 1'b0;
    M_TDATA  = S_TDATA[grant_idx*TDATAW +: TDATAW];
    M_TLAST  = S_TLAST[grant_idx];
    M_TDEST  = S_TDEST[grant_idx*TDESTW +: TDESTW];
    if (state == LOCK) begin
      M_TVALID            = S_TVALID[grant_idx];
      S_TREADY[grant_idx] = M_TREADY;
    end
  end

  assign beat = M_TVALID && M_TREADY;

  // Arbitration FSM: grant in IDLE, hold through the packet in LOCK, move the
  // round-robin pointer past the finished source so it drops to lowest priority.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      beat_cnt  <= '0;
      len_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ENABLE && pick_vld) begin
            grant_idx <= pick_idx;
            beat_cnt  <= '0;
            state     <= LOCK;
          end
        end
        LOCK: begin
          if (beat) begin
            if (M_TLAST) begin
              state  <= IDLE;
              rr_ptr <= wrap_inc(grant_idx);
            end else begin
              // A non-final beat at this count means the packet already
              // exceeds MAX_BEATS; flag it but keep forwarding.
              if (beat_cnt == CNTW'(MAX_BEATS - 1)) len_err <= 1'b1;
              beat_cnt <= sat_inc(beat_cnt);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY      = (state == LOCK);
  assign GRANT_IDX = grant_idx;
  assign LEN_ERR   = len_err;

endmodule

// File: tb/tb_axis_inject_arbiter.sv
// Bench for axis_inject_arbiter: directed scenarios followed by random
// traffic, all compared every cycle against a packet-level reference model.
module tb_axis_inject_arbiter;

  localparam int NUM_SRC   = 4;
  localparam int TDATAW    = 32;
  localparam int TDESTW    = 4;
  localparam int MAX_BEATS = 16;
  localparam int IDXW      = $clog2(NUM_SRC);

  logic                      CLK = 1'b0;
  logic                      RST_N;
  logic                      ENABLE;
  logic [NUM_SRC-1:0]        S_TVALID;
  logic [NUM_SRC-1:0]        S_TREADY;
  logic [NUM_SRC*TDATAW-1:0] S_TDATA;
  logic [NUM_SRC-1:0]        S_TLAST;
  logic [NUM_SRC*TDESTW-1:0] S_TDEST;
  logic                      M_TVALID;
  logic                      M_TREADY;
  logic [TDATAW-1:0]         M_TDATA;
  logic                      M_TLAST;
  logic [TDESTW-1:0]         M_TDEST;
  logic                      BUSY;
  logic [IDXW-1:0]           GRANT_IDX;
  logic                      LEN_ERR;

  axis_inject_arbiter #(
    .NUM_SRC(NUM_SRC), .TDATAW(TDATAW), .TDESTW(TDESTW), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE),
    .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA),
    .S_TLAST(S_TLAST), .S_TDEST(S_TDEST),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA),
    .M_TLAST(M_TLAST), .M_TDEST(M_TDEST),
    .BUSY(BUSY), .GRANT_IDX(GRANT_IDX), .LEN_ERR(LEN_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [TDATAW-1:0] data;
    logic              last;
    logic [TDESTW-1:0] dest;
  } beat_t;

  typedef struct {
    int                src;
    logic [TDATAW-1:0] data;
    logic              last;
    int                cyc;
  } obs_t;

  beat_t srcq [NUM_SRC][$];
  obs_t  outlog [$];
  bit    pend [NUM_SRC];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int valid_pct = 100;

  // reference model: who owns the port (-1 = nobody), who finished last,
  // beats delivered in the current packet, sticky length error
  int m_owner = -1;
  int m_ptr = 0;
  int m_grant = 0;
  int m_pkt_beats = 0;
  bit m_lenerr = 1'b0;
  bit m_known = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(input int s, input int len, input logic [TDATAW-1:0] base,
                         input logic [TDESTW-1:0] dest);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = base + TDATAW'(k);
      b.last = (k == len - 1);
      b.dest = dest;
      srcq[s].push_back(b);
    end
  endtask

  function automatic int pending_beats();
    int t = 0;
    for (int i = 0; i < NUM_SRC; i++) t += srcq[i].size();
    return t;
  endfunction

  task automatic drive_sources();
    for (int i = 0; i < NUM_SRC; i++) begin
      if (srcq[i].size() == 0) begin
        S_TVALID[i] = 1'b0;
        S_TLAST[i]  = 1'b0;
        S_TDATA[i*TDATAW +: TDATAW] = '0;
        S_TDEST[i*TDESTW +: TDESTW] = '0;
      end else begin
        S_TVALID[i] = pend[i] || (int'($urandom_range(0, 99)) < valid_pct);
        S_TLAST[i]  = srcq[i][0].last;
        S_TDATA[i*TDATAW +: TDATAW] = srcq[i][0].data;
        S_TDEST[i*TDESTW +: TDESTW] = srcq[i][0].dest;
      end
    end
  endtask

  task automatic check_outputs();
    logic             mv;
    logic [NUM_SRC-1:0] er;
    mv = (m_owner >= 0) && S_TVALID[m_owner];
    er = '0;
    if (m_owner >= 0 && M_TREADY) er[m_owner] = 1'b1;
    chk("busy", 64'(BUSY), 64'(m_owner >= 0));
    chk("m_tvalid", 64'(M_TVALID), 64'(mv));
    chk("s_tready", 64'(S_TREADY), 64'(er));
    chk("grant_idx", 64'(GRANT_IDX), 64'(m_grant));
    chk("len_err", 64'(LEN_ERR), 64'(m_lenerr));
    if (mv) begin
      chk("m_tdata", 64'(M_TDATA), 64'(srcq[m_owner][0].data));
      chk("m_tlast", 64'(M_TLAST), 64'(srcq[m_owner][0].last));
      chk("m_tdest", 64'(M_TDEST), 64'(srcq[m_owner][0].dest));
    end
  endtask

  task automatic advance();
    bit mv, bt, lst, l2;
    int best, bestd, d, o;
    obs_t ob;
    mv  = (m_owner >= 0) && S_TVALID[m_owner];
    bt  = mv && M_TREADY;
    lst = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) pend[i] = S_TVALID[i] && !(bt && i == m_owner);
    if (bt) begin
      lst = srcq[m_owner][0].last;
      ob.src = m_owner; ob.data = srcq[m_owner][0].data; ob.last = lst; ob.cyc = cyc;
      outlog.push_back(ob);
      void'(srcq[m_owner].pop_front());
      m_pkt_beats++;
    end
    if (!RST_N) begin
      // a partially delivered packet is abandoned by its source
      o = m_owner;
      if (o >= 0 && m_pkt_beats > 0 && !(bt && lst)) begin
        while (srcq[o].size() > 0) begin
          l2 = srcq[o][0].last;
          void'(srcq[o].pop_front());
          if (l2) break;
        end
      end
      m_owner = -1; m_ptr = 0; m_grant = 0; m_pkt_beats = 0; m_lenerr = 1'b0;
      m_known = 1'b1;
      for (int i = 0; i < NUM_SRC; i++) pend[i] = 1'b0;
    end else if (m_owner < 0) begin
      best = -1; bestd = NUM_SRC;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (S_TVALID[i]) begin
          d = (i - m_ptr + NUM_SRC) % NUM_SRC;
          if (d < bestd) begin bestd = d; best = i; end
        end
      end
      if (ENABLE && best >= 0) begin
        m_owner = best; m_grant = best; m_pkt_beats = 0;
      end
    end else if (bt) begin
      if (lst) begin
        m_ptr = (m_owner + 1) % NUM_SRC;
        m_owner = -1;
      end else if (m_pkt_beats >= MAX_BEATS) begin
        m_lenerr = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    drive_sources();
    #1;
    if (m_known) check_outputs();
    advance();
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  initial begin
    int t0, n, s;
    logic [5:0] pat;
    RST_N = 1'b0; ENABLE = 1'b1; M_TREADY = 1'b1;
    S_TVALID = '0; S_TLAST = '0; S_TDATA = '0; S_TDEST = '0;
    for (int i = 0; i < NUM_SRC; i++) pend[i] = 1'b0;
    @(negedge CLK);

    // reset state
    repeat (2) cycle();
    RST_N = 1'b1;
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_m_tvalid", 64'(M_TVALID), 64'(0));
    chk("rst_s_tready", 64'(S_TREADY), 64'(0));
    chk("rst_grant", 64'(GRANT_IDX), 64'(0));
    chk("rst_len_err", 64'(LEN_ERR), 64'(0));

    // T1 single source, 3 beats
    outlog.delete(); t0 = cyc;
    add_pkt(1, 3, 32'hA0, 4'd1);
    repeat (8) cycle();
    chk("t1_nbeats", 64'(outlog.size()), 64'(3));
    for (int k = 0; k < 3 && k < outlog.size(); k++) begin
      chk("t1_data", 64'(outlog[k].data), 64'(32'hA0 + k));
      chk("t1_src", 64'(outlog[k].src), 64'(1));
      chk("t1_cyc", 64'(outlog[k].cyc), 64'(t0 + 1 + k));
    end
    chk("t1_grant", 64'(GRANT_IDX), 64'(1));
    chk("t1_busy", 64'(BUSY), 64'(0));

    // T2 all sources at once from reset
    RST_N = 1'b0; repeat (2) cycle(); RST_N = 1'b1;
    outlog.delete(); t0 = cyc;
    for (int i = 0; i < NUM_SRC; i++) add_pkt(i, 2, 32'hB0 + 32'(16 * i), TDESTW'(i));
    repeat (20) cycle();
    chk("t2_nbeats", 64'(outlog.size()), 64'(8));
    for (int k = 0; k < 8 && k < outlog.size(); k++) begin
      chk("t2_src", 64'(outlog[k].src), 64'(k / 2));
      chk("t2_data", 64'(outlog[k].data), 64'(32'hB0 + 16 * (k / 2) + (k % 2)));
      chk("t2_cyc", 64'(outlog[k].cyc), 64'(t0 + 1 + 3 * (k / 2) + (k % 2)));
    end

    // T3 router backpressure 1,0,0,1 during a 4-beat packet
    outlog.delete();
    add_pkt(2, 4, 32'hC0, 4'd2);
    M_TREADY = 1'b1;
    cycle();
    pat = 6'b100111;
    for (int j = 0; j < 6; j++) begin
      M_TREADY = pat[5-j];
      cycle();
    end
    M_TREADY = 1'b1;
    repeat (3) cycle();
    chk("t3_nbeats", 64'(outlog.size()), 64'(4));
    for (int k = 0; k < 4 && k < outlog.size(); k++)
      chk("t3_data", 64'(outlog[k].data), 64'(32'hC0 + k));
    chk("t3_busy", 64'(BUSY), 64'(0));

    // T4 17-beat packet trips the length watchdog on beat 16
    outlog.delete();
    add_pkt(3, 17, 32'h100, 4'd3);
    cycle();
    repeat (15) cycle();
    chk("t4_len_err_b15", 64'(LEN_ERR), 64'(0));
    cycle();
    chk("t4_len_err_b16", 64'(LEN_ERR), 64'(1));
    repeat (4) cycle();
    chk("t4_nbeats", 64'(outlog.size()), 64'(17));
    if (outlog.size() == 17) begin
      chk("t4_last_data", 64'(outlog[16].data), 64'(32'h110));
      chk("t4_last_flag", 64'(outlog[16].last), 64'(1));
    end

    // T5 ENABLE dropped mid-packet
    outlog.delete();
    add_pkt(0, 4, 32'hD0, 4'd0);
    repeat (3) cycle();
    ENABLE = 1'b0;
    add_pkt(2, 2, 32'hE0, 4'd2);
    repeat (8) cycle();
    chk("t5_nbeats_held", 64'(outlog.size()), 64'(4));
    chk("t5_busy_held", 64'(BUSY), 64'(0));
    chk("t5_len_err_sticky", 64'(LEN_ERR), 64'(1));
    ENABLE = 1'b1;
    cycle();
    chk("t5_busy_en", 64'(BUSY), 64'(1));
    chk("t5_grant_en", 64'(GRANT_IDX), 64'(2));
    repeat (4) cycle();
    chk("t5_nbeats", 64'(outlog.size()), 64'(6));

    // T6 reset after beat 2 of 4
    outlog.delete();
    add_pkt(1, 4, 32'hF0, 4'd1);
    M_TREADY = 1'b1;
    repeat (3) cycle();
    chk("t6_beats_before", 64'(outlog.size()), 64'(2));
    RST_N = 1'b0; M_TREADY = 1'b0;
    cycle();
    chk("t6_m_tvalid", 64'(M_TVALID), 64'(0));
    chk("t6_s_tready", 64'(S_TREADY), 64'(0));
    chk("t6_busy", 64'(BUSY), 64'(0));
    chk("t6_len_err", 64'(LEN_ERR), 64'(0));
    RST_N = 1'b1; M_TREADY = 1'b1;
    outlog.delete();
    add_pkt(1, 2, 32'h1F0, 4'd1);
    add_pkt(0, 2, 32'h0F0, 4'd0);
    repeat (10) cycle();
    chk("t6_nbeats", 64'(outlog.size()), 64'(4));
    if (outlog.size() > 0) chk("t6_first_src", 64'(outlog[0].src), 64'(0));

    // random traffic with source stalls, router stalls and ENABLE toggling
    valid_pct = 70;
    for (int r = 0; r < 1500; r++) begin
      s = int'($urandom_range(0, NUM_SRC - 1));
      if (srcq[s].size() < 12 && $urandom_range(0, 3) == 0)
        add_pkt(s, int'($urandom_range(1, 6)), $urandom, TDESTW'($urandom_range(0, 15)));
      M_TREADY = ($urandom_range(0, 3) != 0);
      ENABLE   = ($urandom_range(0, 9) != 0);
      cycle();
    end
    ENABLE = 1'b1; M_TREADY = 1'b1; valid_pct = 100;
    n = 0;
    while ((pending_beats() > 0 || m_owner >= 0) && n < 400) begin
      cycle();
      n++;
    end
    chk("drain_done", 64'(n < 400), 64'(1));
    cycle();
    chk("final_busy", 64'(BUSY), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
